// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared FSM state encodings and handshake constants for the divider
package ex_div_unit_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
endpackage

// File: rtl/ex_div_unit_if.sv
// ex_div_unit_if: request/result bundle between the EX stage (master) and the divider (slave)
interface ex_div_unit_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_unit_div_step.sv
// div_step: one restoring shift-subtract step; quo_i shifts dividend bits out and quotient bits in
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] part, diff;
  assign part  = {rem_i, quo_i[WIDTH-1]};
  assign diff  = part - {1'b0, dvsr_i};
  // part < 2*divisor, so a borrow always shows up in the top bit
  assign rem_o = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle signed/unsigned restoring divider producing {remainder, quotient}
module ex_div_unit import ex_div_unit_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  ex_div_unit_if.slave div_if
);
  localparam int CW = $clog2(WIDTH);
  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic               s1_q, s1_d, s2_q, s2_d, ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   rem_s, quo_s, mag1, mag2, q_fix, r_fix;
  logic               neg1, neg2, accept;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (rem_s),
    .quo_o (quo_s)
  );
  assign accept = (div_if.start_i == DivStart) && !div_if.annul_i;
  assign neg1   = div_if.signed_div_i && div_if.opdata1_i[WIDTH-1];
  assign neg2   = div_if.signed_div_i && div_if.opdata2_i[WIDTH-1];
  assign mag1   = neg1 ? -div_if.opdata1_i : div_if.opdata1_i;
  assign mag2   = neg2 ? -div_if.opdata2_i : div_if.opdata2_i;
  assign q_fix  = (s1_q ^ s2_q) ? -quo_s : quo_s;
  assign r_fix  = s1_q ? -rem_s : rem_s;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    ready_d  = ready_q;
    result_d = result_q;
    unique case (state_q)
      DivFree: begin
        if (accept && div_if.opdata2_i == '0) begin
          state_d = DivByZero;
        end else if (accept) begin
          state_d = DivOn;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag1;
          dvsr_d  = mag2;
          s1_d    = neg1;
          s2_d    = neg2;
        end
      end
      DivByZero: begin
        state_d  = div_if.annul_i ? DivFree : DivEnd;
        ready_d  = div_if.annul_i ? DivResultNotReady : DivResultReady;
        result_d = '0;
      end
      DivOn: begin
        if (div_if.annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d = rem_s;
          quo_d = quo_s;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = DivEnd;
            ready_d  = DivResultReady;
            result_d = {r_fix, q_fix};
          end
        end
      end
      DivEnd: begin
        if (div_if.start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      ready_q  <= DivResultNotReady;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end
  assign div_if.result_o   = result_q;
  assign div_if.ready_o    = ready_q;
  assign div_if.stallreq_o = (state_q == DivByZero) || (state_q == DivOn) || (state_q == DivFree && accept);
endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed vectors for the divider at WIDTH=32 and WIDTH=8
module tb_ex_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  ex_div_unit_if #(.WIDTH(32)) d32 ();
  ex_div_unit_if #(.WIDTH(8))  d8 ();
  ex_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .div_if(d32));
  ex_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .div_if(d8));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic op32(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int lat);
    int n;
    d32.signed_div_i = sgn;
    d32.opdata1_i    = a;
    d32.opdata2_i    = b;
    d32.annul_i      = 1'b0;
    d32.start_i      = 1'b1;
    #1 chk({tag, "_stall_req"}, 64'(d32.stallreq_o), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
      d32.opdata1_i    = 32'hdead_beef;
      d32.opdata2_i    = 32'h0;
      d32.signed_div_i = ~sgn;
    end while (!d32.ready_o && n < 100);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_result"}, d32.result_o, exp);
    chk({tag, "_stall_end"}, 64'(d32.stallreq_o), 64'd0);
    tick();
    chk({tag, "_hold_ready"}, 64'(d32.ready_o), 64'd1);
    chk({tag, "_hold_result"}, d32.result_o, exp);
    d32.start_i = 1'b0;
    tick();
    chk({tag, "_drop_ready"}, 64'(d32.ready_o), 64'd0);
    chk({tag, "_drop_result"}, d32.result_o, 64'd0);
  endtask
  initial begin
    int  n;
    bit  seen;
    d32.signed_div_i = 1'b0; d32.opdata1_i = '0; d32.opdata2_i = '0; d32.start_i = 1'b0; d32.annul_i = 1'b0;
    d8.signed_div_i  = 1'b0; d8.opdata1_i  = '0; d8.opdata2_i  = '0; d8.start_i  = 1'b0; d8.annul_i  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(d32.ready_o), 64'd0);
    chk("rst_result", d32.result_o, 64'd0);
    chk("rst_stall", 64'(d32.stallreq_o), 64'd0);
    rst = 1'b1;
    tick();
    op32("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    op32("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    op32("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    op32("div0", 1'b0, 32'd5, 32'd0, 64'd0, 2);
    op32("minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    op32("u_max", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 33);
    // annul while FREE must keep the unit idle
    d32.opdata1_i = 32'd100; d32.opdata2_i = 32'd7; d32.start_i = 1'b1; d32.annul_i = 1'b1;
    #1 chk("annul_free_stall", 64'(d32.stallreq_o), 64'd0);
    tick();
    d32.start_i = 1'b0; d32.annul_i = 1'b0;
    #1 chk("annul_free_idle", 64'(d32.stallreq_o), 64'd0);
    tick();
    // flush at cycle 10
    d32.signed_div_i = 1'b0; d32.opdata1_i = 32'd100; d32.opdata2_i = 32'd7; d32.start_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= d32.ready_o;
    end
    d32.annul_i = 1'b1; d32.start_i = 1'b0;
    tick();
    seen |= d32.ready_o;
    d32.annul_i = 1'b0;
    chk("flush_stall", 64'(d32.stallreq_o), 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= d32.ready_o;
    end
    chk("flush_no_ready", 64'(seen), 64'd0);
    op32("flush_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    // reset at cycle 5
    d32.opdata1_i = 32'd100; d32.opdata2_i = 32'd7; d32.start_i = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready", 64'(d32.ready_o), 64'd0);
    chk("midrst_result", d32.result_o, 64'd0);
    rst = 1'b1; d32.start_i = 1'b0;
    tick();
    chk("midrst_idle", 64'(d32.stallreq_o), 64'd0);
    op32("rst_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    // WIDTH=8 instance
    d8.opdata1_i = 8'd255; d8.opdata2_i = 8'd16; d8.start_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      d8.opdata1_i = 8'd3;
    end while (!d8.ready_o && n < 100);
    chk("w8_latency", 64'(n), 64'd9);
    chk("w8_result", 64'(d8.result_o), 64'({8'd15, 8'd15}));
    d8.start_i = 1'b0;
    tick();
    chk("w8_drop", 64'(d8.ready_o), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
